// File: rtl/i2s_mic_deserializer.sv
// I2S receiver for one microphone pair: oversamples BCLK/LRCLK/DIN in the CLK domain and emits aligned {left,right} words.
// Optional feature macro I2S_ROUND_EN: round half-up with positive saturation before word reduction (default: truncation).
module i2s_mic_deserializer #(
  parameter int SAMPLE_BITS = 24,
  parameter int OUT_BITS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  enable,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  GPIO_DIN1,
  output logic [OUT_BITS-1:0]   sample_left,
  output logic [OUT_BITS-1:0]   sample_right,
  output logic [2*OUT_BITS-1:0] codec_stream,
  output logic                  sample_valid,
  output logic                  frame_err
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, PAD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] bclk_sync, ws_sync, din_sync;
  logic                   bclk_prev, ws_prev;
  logic                   bclk_s, ws_s, din_s;
  logic                   bclk_rise, ws_edge;
  logic [SAMPLE_BITS-1:0] sreg, word_next;
  logic [OUT_BITS-1:0]    reduced, hold;
  logic [CW-1:0]          bitcnt;
  logic                   chan_right, left_ok;

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign ws_s      = ws_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev;
  assign ws_edge   = ws_s ^ ws_prev;
  assign word_next = {sreg[SAMPLE_BITS-2:0], din_s};

`ifdef I2S_ROUND_EN
  localparam logic [SAMPLE_BITS:0] BIAS = {{SAMPLE_BITS{1'b0}}, 1'b1} << (SAMPLE_BITS - OUT_BITS - 1);
  logic [SAMPLE_BITS:0] rounded;
  assign rounded = {word_next[SAMPLE_BITS-1], word_next} + BIAS;
  // Only a non-negative word can carry into the sign bit; clamp it to the largest positive code.
  assign reduced = (!word_next[SAMPLE_BITS-1] && rounded[SAMPLE_BITS-1])
                   ? {1'b0, {(OUT_BITS-1){1'b1}}}
                   : rounded[SAMPLE_BITS-1 -: OUT_BITS];
`else
  assign reduced = word_next[SAMPLE_BITS-1 -: OUT_BITS];
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      bclk_sync    <= '0;
      ws_sync      <= '0;
      din_sync     <= '0;
      bclk_prev    <= 1'b0;
      ws_prev      <= 1'b0;
      sreg         <= '0;
      hold         <= '0;
      bitcnt       <= '0;
      chan_right   <= 1'b0;
      left_ok      <= 1'b0;
      sample_left  <= '0;
      sample_right <= '0;
      codec_stream <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      bclk_sync    <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      ws_sync      <= {ws_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      din_sync     <= {din_sync[SYNC_STAGES-2:0], GPIO_DIN1};
      bclk_prev    <= bclk_s;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      // Word select is tracked even while idle so re-enable sees true edges only.
      if (bclk_rise) ws_prev <= ws_s;

      if (!enable) begin
        state   <= IDLE;
        left_ok <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (bclk_rise && ws_edge && !ws_s) begin
              state      <= SHIFT;
              chan_right <= 1'b0;
              bitcnt     <= '0;
              left_ok    <= 1'b0;
            end
          end
          SHIFT: begin
            if (bclk_rise) begin
              if (ws_edge) begin
                frame_err <= 1'b1;
                left_ok   <= 1'b0;
                state     <= ARM;
              end else begin
                sreg   <= word_next;
                bitcnt <= bitcnt + 1'b1;
                if (bitcnt == CW'(SAMPLE_BITS - 1)) begin
                  state <= PAD;
                  if (!chan_right) begin
                    hold    <= reduced;
                    left_ok <= 1'b1;
                  end else begin
                    left_ok <= 1'b0;
                    if (left_ok) begin
                      sample_left  <= hold;
                      sample_right <= reduced;
                      codec_stream <= {hold, reduced};
                      sample_valid <= 1'b1;
                    end
                  end
                end
              end
            end
          end
          PAD: begin
            // The bit at the edge still belongs to the old slot; the MSB arrives on the next rise.
            if (bclk_rise && ws_edge) begin
              state      <= SHIFT;
              chan_right <= ws_s;
              bitcnt     <= '0;
              if (!ws_s) left_ok <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
